// File: rtl/sensores_nav_ctrl_if.sv
// Sensor and actuator bundle for the wall-following navigation controller.
// master: the side driving the raw sensors and start command.
// slave:  the controller itself.
interface sensores_nav_ctrl_if;
   logic       start;
   logic       head;
   logic       left;
   logic       under;
   logic       barreira;
   logic       avancar;
   logic       girar;
   logic       remover;
   logic       fault;
   logic [2:0] state_out;

   modport master (
      output start, head, left, under, barreira,
      input  avancar, girar, remover, fault, state_out
   );

   modport slave (
      input  start, head, left, under, barreira,
      output avancar, girar, remover, fault, state_out
   );
endinterface

// File: rtl/sensores_nav_ctrl.sv
// Wall-following navigation controller: synchronises and debounces the raw
// sensors, then runs a Moore FSM with registered motor/actuator outputs,
// timed turns, timed debris removal, stuck detection and a sticky fault.
module sensores_nav_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TURN_CYCLES     = 8,
   parameter int unsigned REMOVE_CYCLES   = 16,
   parameter int unsigned STUCK_LIMIT     = 3,
   parameter int unsigned CNT_W           = 8
) (
   input logic                 c1,
   input logic                 reset,
   sensores_nav_ctrl_if.slave  bus
);

   localparam int unsigned SW = $clog2(STUCK_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] REMOVE_LOAD = CNT_W'(REMOVE_CYCLES - 1);
   localparam logic [SW-1:0]    STUCK_LAST  = SW'(STUCK_LIMIT - 1);

   typedef enum logic [2:0] {
      ST_PROCURANDO   = 3'b000,
      ST_ACOMPANHANDO = 3'b010,
      ST_REMOVENDO    = 3'b011,
      ST_GIRA         = 3'b100,
      ST_FAULT        = 3'b101,
      ST_STANDBY      = 3'b111
   } state_t;

   // bit order: 0 head, 1 left, 2 under, 3 barreira, 4 start
   logic [4:0] raw;
   logic [4:0] sync1_q;
   logic [4:0] sync2_q;
   logic       start_prev_q;
   logic [3:0] filt;

   assign raw = {bus.start, bus.barreira, bus.under, bus.left, bus.head};

   // Two-flop synchronisers plus previous start sample for edge detection
   always_ff @(posedge c1 or negedge reset) begin
      if (!reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         start_prev_q <= 1'b0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         start_prev_q <= sync2_q[4];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic             filt_q;

      // Filtered value follows the synced one after DEBOUNCE_CYCLES consecutive differing samples
      always_ff @(posedge c1 or negedge reset) begin
         if (!reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
         end else if (sync2_q[g] == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DEB_LAST) begin
            cnt_q  <= '0;
            filt_q <= sync2_q[g];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign filt[g] = filt_q;
   end

   logic head_f, left_f, under_f, barreira_f, start_s, start_rise;
   assign head_f     = filt[0];
   assign left_f     = filt[1];
   assign under_f    = filt[2];
   assign barreira_f = filt[3];
   assign start_s    = sync2_q[4];
   assign start_rise = sync2_q[4] & ~start_prev_q;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [SW-1:0]     stuck_q, stuck_d;
   logic              avancar_q, avancar_d;
   logic              girar_q, girar_d;
   logic              remover_q, remover_d;
   logic              fault_q, fault_d;

   // State, timers and registered Moore outputs
   always_ff @(posedge c1 or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_STANDBY;
         timer_q   <= '0;
         stuck_q   <= '0;
         avancar_q <= 1'b0;
         girar_q   <= 1'b0;
         remover_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         stuck_q   <= stuck_d;
         avancar_q <= avancar_d;
         girar_q   <= girar_d;
         remover_q <= remover_d;
         fault_q   <= fault_d;
      end
   end

   // Next state with priority under > start lost > fault > barreira > head > local rule
   always_comb begin
      state_d   = state_q;
      timer_d   = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
      stuck_d   = stuck_q;
      avancar_d = 1'b0;
      girar_d   = 1'b0;
      remover_d = 1'b0;
      fault_d   = 1'b0;

      case (state_q)
         ST_STANDBY: begin
            if (start_s && !under_f) state_d = ST_PROCURANDO;
         end
         ST_FAULT: begin
            if (start_rise) state_d = ST_STANDBY;
         end
         default: begin
            if (under_f || !start_s) begin
               state_d = ST_STANDBY;
            end else if (state_q == ST_GIRA) begin
               // head/barreira are only looked at once the turn has run out
               if (timer_q == '0) begin
                  if (head_f && stuck_q == STUCK_LAST) begin
                     state_d = ST_FAULT;
                  end else if (barreira_f) begin
                     state_d = ST_REMOVENDO;
                     timer_d = REMOVE_LOAD;
                  end else if (head_f) begin
                     stuck_d = stuck_q + 1'b1;
                     timer_d = TURN_LOAD;
                  end else begin
                     state_d = left_f ? ST_ACOMPANHANDO : ST_PROCURANDO;
                  end
               end
            end else if (state_q == ST_REMOVENDO) begin
               if (barreira_f && timer_q == '0) begin
                  state_d = ST_FAULT;
               end else if (!barreira_f) begin
                  state_d = left_f ? ST_ACOMPANHANDO : ST_PROCURANDO;
               end
            end else if (barreira_f) begin
               state_d = ST_REMOVENDO;
               timer_d = REMOVE_LOAD;
            end else if (head_f) begin
               state_d = ST_GIRA;
               timer_d = TURN_LOAD;
            end else if (state_q == ST_PROCURANDO && left_f) begin
               state_d = ST_ACOMPANHANDO;
            end else if (state_q == ST_ACOMPANHANDO && !left_f) begin
               state_d = ST_PROCURANDO;
            end
         end
      endcase

      if (state_d != ST_GIRA) stuck_d = '0;

      case (state_d)
         ST_PROCURANDO, ST_ACOMPANHANDO: avancar_d = 1'b1;
         ST_REMOVENDO: begin
            avancar_d = 1'b1;
            remover_d = 1'b1;
         end
         ST_GIRA:  girar_d = 1'b1;
         ST_FAULT: fault_d = 1'b1;
         default:  ;
      endcase
   end

   assign bus.avancar   = avancar_q;
   assign bus.girar     = girar_q;
   assign bus.remover   = remover_q;
   assign bus.fault     = fault_q;
   assign bus.state_out = state_q;

endmodule

// File: doc/sensores_nav_ctrl.md
Name: sensores_nav_ctrl

Overview:
- Parametrised successor of the wall-following sensor FSM in the robot navigation path. Sits between the raw bumper/IR sensors and the motor driver.
- Synchronises and debounces every sensor input, then runs a Moore FSM with registered outputs.
- Adds timed turns, a timed debris-removal action with timeout, stuck detection, a sticky fault state and an explicit start command.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synced samples required before a filtered sensor value changes (>=1).
- TURN_CYCLES, 8: cycles girar stays asserted per turn (>=1).
- REMOVE_CYCLES, 16: maximum cycles in the debris-removal state before a fault is declared (>=1).
- STUCK_LIMIT, 3: consecutive turns with head still blocked that trigger a fault (>=1).
- CNT_W, 8: timer width. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, TURN_CYCLES, REMOVE_CYCLES).

Ports:
- c1  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run command, asynchronous level; 2-FF synchronised, not debounced.
- head  in  1  front obstacle sensor, asynchronous.
- left  in  1  left wall sensor, asynchronous.
- under  in  1  floor/cliff sensor, asynchronous; 1 = unsafe.
- barreira  in  1  debris-in-path sensor, asynchronous.
- avancar  out  1  drive forward.
- girar  out  1  rotate right.
- remover  out  1  debris-removal actuator.
- fault  out  1  sticky fault flag.
- state_out  out  3  current FSM state code.

Behaviour:
- Reset (reset=0, async): state=STANDBY; avancar, girar, remover, fault = 0; state_out=3'b111. Sync flops, filtered values and all counters = 0. Reset mid-turn or mid-removal aborts immediately; nothing is retained.
- Input path: 2-FF synchroniser per input, then a debouncer on head, left, under, barreira.
  - Per-input counter increments while synced != filtered and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, filtered takes the synced value and the counter clears.
  - A raw pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Latency: a raw change at edge k reaches filtered at edge k+2+DEBOUNCE_CYCLES. State and outputs change at edge k+3+DEBOUNCE_CYCLES (7 with defaults).
- Outputs are Moore and registered: they update on the same edge the state register does.
- State codes:
  - STANDBY 111: all outputs 0.
  - PROCURANDO 000: avancar=1.
  - ACOMPANHANDO 010: avancar=1.
  - REMOVENDO 011: avancar=1, remover=1.
  - GIRA 100: girar=1.
  - FAULT 101: fault=1, motion outputs 0.
- Transition priority in every active state (PROCURANDO, ACOMPANHANDO, GIRA, REMOVENDO), evaluated on filtered inputs, highest first:
  1. under=1 -> STANDBY.
  2. Fault conditions.
  3. barreira=1 -> REMOVENDO.
  4. head=1 -> GIRA.
  5. State-specific rule.
- STANDBY: start_sync=1 and under=0 -> PROCURANDO. Otherwise stay.
- PROCURANDO: left=1 -> ACOMPANHANDO. Otherwise stay.
- ACOMPANHANDO: left=0 -> PROCURANDO (wall lost). Otherwise stay.
- Leaving any active state on start_sync=0 -> STANDBY. This has priority just below under.
- GIRA:
  - Timer loads TURN_CYCLES-1 on entry; girar is high exactly TURN_CYCLES cycles. barreira and head are not re-evaluated mid-turn; under and start still are.
  - At timer=0 with head=1: if stuck_cnt==STUCK_LIMIT-1 -> FAULT; else stuck_cnt++ and reload the timer (stay in GIRA).
  - At timer=0 with head=0: -> ACOMPANHANDO if left=1, else PROCURANDO. stuck_cnt clears on any exit from GIRA.
- REMOVENDO:
  - Timer loads REMOVE_CYCLES-1 on entry.
  - barreira=0 before expiry -> ACOMPANHANDO if left=1, else PROCURANDO.
  - Timer=0 with barreira still 1 -> FAULT. head is ignored in this state.
- FAULT: sticky. Exits to STANDBY only on a rising edge of start_sync (0 then 1 on consecutive cycles), and fault clears on that edge. under is ignored here.
- Timers saturate at 0 and never wrap. Counters are unsigned, CNT_W bits. stuck_cnt uses $clog2(STUCK_LIMIT+1) bits.

Test Plan:
- Reset then start=1, all sensors 0 -> state_out 111 -> 000 with avancar=1 on the 3rd edge after start; a 3-cycle head pulse causes no transition (filtered away, DEBOUNCE_CYCLES=4).
- In PROCURANDO, raise left -> ACOMPANHANDO (010) 7 edges later; drop left -> back to 000 7 edges after the drop.
- In ACOMPANHANDO, pulse head for 6 cycles -> GIRA with girar=1 for exactly 8 cycles, then ACOMPANHANDO (left=1).
- Hold head=1 -> girar high 24 consecutive cycles, then FAULT (101), fault=1; start toggled 1->0->1 -> STANDBY, fault=0.
- barreira=1 held -> REMOVENDO with remover=1 for 16 cycles, then FAULT. Repeat with barreira dropped after 10 cycles -> return to 000/010 and no fault.
- under=1 asserted mid-GIRA, and separately reset=0 mid-REMOVENDO -> STANDBY, all outputs 0. under transition at DEBOUNCE latency; reset immediately (asynchronous).
